// File: rtl/simon_pkg.sv
// Shared types and constants for the SIMON32/64 decrypt key expander.
package simon_pkg;

   localparam int WORD_W     = 16;
   localparam int NUM_ROUNDS = 32;
   localparam int KEY_WORDS  = 4;

   localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;
   // z0 sequence, bit 0 of the sequence is the MSB
   localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [4:0]        rnd_idx_t;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      SERVE
   } keyexp_state_t;

   function automatic word_t ror(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic z0_bit(input rnd_idx_t i);
      logic [61:0] sh;
      sh = Z0 << i;
      return sh[61];
   endfunction

endpackage

// File: rtl/simon_decrypt_key_expander_if.sv
// Key-in / round-key-out handshake bundle. The replay input exists only when
// SIMON_KEYEXP_REPLAY_EN is defined.
interface simon_decrypt_key_expander_if;
   import simon_pkg::*;

   logic     key_valid;
   logic     key_ready;
   logic [63:0] key;
   logic     rk_valid;
   logic     rk_ready;
   word_t    rk;
   rnd_idx_t rk_round;
   logic     busy;
   logic     done;
`ifdef SIMON_KEYEXP_REPLAY_EN
   logic     replay;
`endif

`ifdef SIMON_KEYEXP_REPLAY_EN
   modport slave (
      input  key_valid, key, rk_ready, replay,
      output key_ready, rk_valid, rk, rk_round, busy, done
   );
   modport master (
      output key_valid, key, rk_ready, replay,
      input  key_ready, rk_valid, rk, rk_round, busy, done
   );
`else
   modport slave (
      input  key_valid, key, rk_ready,
      output key_ready, rk_valid, rk, rk_round, busy, done
   );
   modport master (
      output key_valid, key, rk_ready,
      input  key_ready, rk_valid, rk, rk_round, busy, done
   );
`endif

endinterface

// File: rtl/simon_keyexp_step.sv
// One SIMON32/64 key-schedule step: k[i+4] from k[i], k[i+1], k[i+3] and z0 bit i.
module simon_keyexp_step
   import simon_pkg::*;
(
   input  word_t k_i,
   input  word_t k_i1,
   input  word_t k_i3,
   input  logic  z_bit,
   output word_t k_i4
);

   word_t t;

   always_comb begin
      t    = ror(k_i3, 3) ^ k_i1;
      // C_CONST folds the reference ~k[i] ^ 3 into a single XOR
      k_i4 = C_CONST ^ k_i ^ t ^ ror(t, 1) ^ {{(WORD_W-1){1'b0}}, z_bit};
   end

endmodule

// File: rtl/simon_decrypt_key_expander.sv
// SIMON32/64 key expander serving round keys k31..k0 to the decrypt datapath.
// Optional stored-schedule replay: define SIMON_KEYEXP_REPLAY_EN.
//
// state  | meaning
// IDLE   | key_ready high, waiting for a key (or replay request)
// EXPAND | writing k4..k31, one word per cycle, exp_cnt counts down 27..0
// SERVE  | presenting regfile[ptr] on rk, ptr counts down 31..0
module simon_decrypt_key_expander
   import simon_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   simon_decrypt_key_expander_if.slave   bus
);

   localparam rnd_idx_t EXP_LAST = rnd_idx_t'(NUM_ROUNDS - KEY_WORDS - 1);
   localparam rnd_idx_t RND_LAST = rnd_idx_t'(NUM_ROUNDS - 1);

   keyexp_state_t state_q, state_d;
   word_t         rf_q [NUM_ROUNDS];
   word_t         rf_d [NUM_ROUNDS];
   rnd_idx_t      exp_cnt_q, exp_cnt_d;
   rnd_idx_t      ptr_q, ptr_d;
   logic          key_ready_q, key_ready_d;
   logic          rk_valid_q, rk_valid_d;
   word_t         rk_q, rk_d;
   rnd_idx_t      rk_round_q, rk_round_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef SIMON_KEYEXP_REPLAY_EN
   logic          sched_ok_q, sched_ok_d;
`endif

   rnd_idx_t exp_i, exp_i1, exp_i3, exp_wr, ptr_m1;
   word_t    k_next;

   assign exp_i  = EXP_LAST - exp_cnt_q;
   assign exp_i1 = exp_i + 5'd1;
   assign exp_i3 = exp_i + 5'd3;
   assign exp_wr = exp_i + 5'd4;
   assign ptr_m1 = ptr_q - 5'd1;

   simon_keyexp_step u_step (
      .k_i   (rf_q[exp_i]),
      .k_i1  (rf_q[exp_i1]),
      .k_i3  (rf_q[exp_i3]),
      .z_bit (z0_bit(exp_i)),
      .k_i4  (k_next)
   );

   always_comb begin
      state_d     = state_q;
      rf_d        = rf_q;
      exp_cnt_d   = exp_cnt_q;
      ptr_d       = ptr_q;
      key_ready_d = key_ready_q;
      rk_valid_d  = rk_valid_q;
      rk_d        = rk_q;
      rk_round_d  = rk_round_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef SIMON_KEYEXP_REPLAY_EN
      sched_ok_d  = sched_ok_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.key_valid && key_ready_q) begin
               rf_d[0]     = bus.key[15:0];
               rf_d[1]     = bus.key[31:16];
               rf_d[2]     = bus.key[47:32];
               rf_d[3]     = bus.key[63:48];
               exp_cnt_d   = EXP_LAST;
               state_d     = EXPAND;
               key_ready_d = 1'b0;
               busy_d      = 1'b1;
`ifdef SIMON_KEYEXP_REPLAY_EN
               sched_ok_d  = 1'b0;
            end else if (bus.replay && sched_ok_q) begin
               ptr_d       = RND_LAST;
               state_d     = SERVE;
               rk_valid_d  = 1'b1;
               rk_d        = rf_q[RND_LAST];
               rk_round_d  = RND_LAST;
               key_ready_d = 1'b0;
               busy_d      = 1'b1;
`endif
            end
         end
         EXPAND: begin
            rf_d[exp_wr] = k_next;
            if (exp_cnt_q == 5'd0) begin
               // k31 is written this edge, so present it straight from the step
               ptr_d      = RND_LAST;
               state_d    = SERVE;
               rk_valid_d = 1'b1;
               rk_d       = k_next;
               rk_round_d = RND_LAST;
`ifdef SIMON_KEYEXP_REPLAY_EN
               sched_ok_d = 1'b1;
`endif
            end else begin
               exp_cnt_d = exp_cnt_q - 5'd1;
            end
         end
         SERVE: begin
            if (bus.rk_ready && rk_valid_q) begin
               if (ptr_q == 5'd0) begin
                  state_d     = IDLE;
                  rk_valid_d  = 1'b0;
                  key_ready_d = 1'b1;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  ptr_d      = ptr_m1;
                  rk_d       = rf_q[ptr_m1];
                  rk_round_d = ptr_m1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         exp_cnt_q   <= '0;
         ptr_q       <= '0;
         key_ready_q <= 1'b1;
         rk_valid_q  <= 1'b0;
         rk_q        <= '0;
         rk_round_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SIMON_KEYEXP_REPLAY_EN
         sched_ok_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         exp_cnt_q   <= exp_cnt_d;
         ptr_q       <= ptr_d;
         key_ready_q <= key_ready_d;
         rk_valid_q  <= rk_valid_d;
         rk_q        <= rk_d;
         rk_round_q  <= rk_round_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SIMON_KEYEXP_REPLAY_EN
         sched_ok_q  <= sched_ok_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      rf_q <= rf_d;
   end

   assign bus.key_ready = key_ready_q;
   assign bus.rk_valid  = rk_valid_q;
   assign bus.rk        = rk_q;
   assign bus.rk_round  = rk_round_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_simon_decrypt_key_expander.sv
// Directed bench: key schedule order/values, latency, backpressure, reset, ignored keys,
// and decryption of the reference SIMON32/64 vector through the served keys.
module tb_simon_decrypt_key_expander;

   localparam logic [63:0] KEY_A  = 64'h1918_1110_0908_0100;
   localparam logic [63:0] KEY_B  = 64'h0123_4567_89AB_CDEF;
   localparam logic [61:0] Z0_REF = 62'b11111010001001010110000111001101111101000100101011000011100110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;
   logic [15:0] exp_k [32];

   always #5 clk = ~clk;

   simon_decrypt_key_expander_if bus_if ();

   simon_decrypt_key_expander dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
      return (x >> n) | (x << (16 - n));
   endfunction

   function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
      return (x << n) | (x >> (16 - n));
   endfunction

   function automatic logic [15:0] simon_f(input logic [15:0] x);
      return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
   endfunction

   // Reference key schedule in the textbook form (~k ^ 3 ^ z)
   task automatic build_model(input logic [63:0] k);
      logic [15:0] tmp;
      logic [61:0] zs;
      for (int i = 0; i < 4; i++) exp_k[i] = k[16*i +: 16];
      for (int i = 4; i < 32; i++) begin
         tmp = rotr(exp_k[i-1], 3) ^ exp_k[i-3];
         tmp = tmp ^ rotr(tmp, 1);
         zs  = Z0_REF << (i - 4);
         exp_k[i] = ~exp_k[i-4] ^ tmp ^ {15'd0, zs[61]} ^ 16'h0003;
      end
   endtask

   task automatic send_key(input logic [63:0] k, input bit poke_busy, input bit with_replay);
      int lat;
      bus_if.key       = k;
      bus_if.key_valid = 1'b1;
`ifdef SIMON_KEYEXP_REPLAY_EN
      bus_if.replay    = with_replay;
`endif
      check_val("key_ready_idle", 64'(bus_if.key_ready), 64'd1);
      @(posedge clk); #1;
      bus_if.key_valid = 1'b0;
`ifdef SIMON_KEYEXP_REPLAY_EN
      bus_if.replay    = 1'b0;
`endif
      if (with_replay) check_val("key_beats_replay", 64'(bus_if.rk_valid), 64'd0);
      lat = 0;
      while (!bus_if.rk_valid && lat < 100) begin
         if (poke_busy && lat == 5) begin
            check_val("key_ready_expand", 64'(bus_if.key_ready), 64'd0);
            bus_if.key       = KEY_B;
            bus_if.key_valid = 1'b1;
         end else begin
            bus_if.key_valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus_if.key_valid = 1'b0;
      check_val("first_rk_latency", 64'(lat), 64'd28);
   endtask

   // mode 0: always ready, 1: random ready with 10-cycle stalls,
   // 2: always ready with a key pulse mid-stream, 3: reset at round 17
   task automatic serve_check(input int mode, input bit do_decrypt);
      int idx = 31;
      int guard = 0;
      int stall = 0;
      int done_cnt = 0;
      bit st_a = 1'b0, st_b = 1'b0, held = 1'b0, aborted = 1'b0;
      logic [15:0] held_rk, x, y, t;
      logic [4:0]  held_rnd;
      logic        rdy;
      x = 16'hC69B;
      y = 16'hE9BB;
      while (idx >= 0 && guard < 3000 && !aborted) begin
         if (held) check_val("rk_stable", {43'd0, bus_if.rk_valid, bus_if.rk_round, bus_if.rk},
                             {43'd0, 1'b1, held_rnd, held_rk});
         if (bus_if.done) done_cnt++;
         if (mode == 3 && bus_if.rk_valid && bus_if.rk_round == 5'd17) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check_val("rst_rk_valid", 64'(bus_if.rk_valid), 64'd0);
            check_val("rst_busy", 64'(bus_if.busy), 64'd0);
            check_val("rst_key_ready", 64'(bus_if.key_ready), 64'd1);
            rst = 1'b0;
            aborted = 1'b1;
         end else begin
            rdy = 1'b1;
            if (mode == 1) begin
               if (stall > 0) begin
                  rdy = 1'b0;
                  stall--;
               end else if (bus_if.rk_valid && idx == 20 && !st_a) begin
                  st_a = 1'b1; stall = 9; rdy = 1'b0;
               end else if (bus_if.rk_valid && idx == 6 && !st_b) begin
                  st_b = 1'b1; stall = 9; rdy = 1'b0;
               end else begin
                  rdy = 1'($urandom_range(0, 1));
               end
            end
            if (mode == 2) begin
               bus_if.key       = KEY_B;
               bus_if.key_valid = (idx == 10);
            end
            bus_if.rk_ready = rdy;
            if (bus_if.rk_valid && rdy) begin
               check_val("rk_value", 64'(bus_if.rk), 64'(exp_k[idx]));
               check_val("rk_round", 64'(bus_if.rk_round), 64'(idx));
               if (do_decrypt && idx == 4) check_val("rk4_71c3", 64'(bus_if.rk), 64'h71C3);
               t = x;
               x = y;
               y = t ^ simon_f(y) ^ bus_if.rk;
               idx--;
               held = 1'b0;
            end else begin
               held     = bus_if.rk_valid;
               held_rk  = bus_if.rk;
               held_rnd = bus_if.rk_round;
            end
            @(posedge clk); #1;
            guard++;
         end
      end
      bus_if.key_valid = 1'b0;
      bus_if.rk_ready  = 1'b0;
      if (!aborted) begin
         check_val("serve_all_taken", 64'(idx), 64'(-1));
         check_val("done_pulse", 64'(bus_if.done), 64'd1);
         check_val("done_key_ready", 64'(bus_if.key_ready), 64'd1);
         check_val("done_busy", 64'(bus_if.busy), 64'd0);
         check_val("done_rk_valid", 64'(bus_if.rk_valid), 64'd0);
         check_val("done_early", 64'(done_cnt), 64'd0);
         if (do_decrypt) check_val("plaintext", 64'({x, y}), 64'h6565_6877);
         @(posedge clk); #1;
         check_val("done_one_cycle", 64'(bus_if.done), 64'd0);
      end
   endtask

   initial begin
      bus_if.key_valid = 1'b0;
      bus_if.key       = '0;
      bus_if.rk_ready  = 1'b0;
`ifdef SIMON_KEYEXP_REPLAY_EN
      bus_if.replay    = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_key_ready", 64'(bus_if.key_ready), 64'd1);
      check_val("rst_rk_valid", 64'(bus_if.rk_valid), 64'd0);
      check_val("rst_busy", 64'(bus_if.busy), 64'd0);
      check_val("rst_done", 64'(bus_if.done), 64'd0);
      check_val("rst_rk", 64'(bus_if.rk), 64'd0);
      check_val("rst_rk_round", 64'(bus_if.rk_round), 64'd0);
      rst = 1'b0;

`ifdef SIMON_KEYEXP_REPLAY_EN
      bus_if.replay = 1'b1;
      @(posedge clk); #1;
      bus_if.replay = 1'b0;
      check_val("replay_no_sched", 64'(bus_if.busy), 64'd0);
`endif

      // nominal
      build_model(KEY_A);
      send_key(KEY_A, 1'b0, 1'b0);
      serve_check(0, 1'b1);

      // backpressure
      send_key(KEY_A, 1'b0, 1'b0);
      serve_check(1, 1'b1);

      // reset mid-stream, then a fresh different key
      send_key(KEY_A, 1'b0, 1'b0);
      serve_check(3, 1'b0);
      build_model(KEY_B);
      send_key(KEY_B, 1'b0, 1'b0);
      serve_check(0, 1'b0);

      // keys offered while busy are dropped
      build_model(KEY_A);
      send_key(KEY_A, 1'b1, 1'b0);
      serve_check(2, 1'b1);

`ifdef SIMON_KEYEXP_REPLAY_EN
      bus_if.replay = 1'b1;
      @(posedge clk); #1;
      bus_if.replay = 1'b0;
      check_val("replay_rk_valid", 64'(bus_if.rk_valid), 64'd1);
      check_val("replay_rk_round", 64'(bus_if.rk_round), 64'd31);
      serve_check(1, 1'b1);
      build_model(KEY_B);
      send_key(KEY_B, 1'b0, 1'b1);
      serve_check(0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
